// File: rtl/t_flip_flop.sv
// Free-running toggle flip-flop: q inverts on every rising clk edge.
// A synchronous active-high reset loads RESET_VAL and takes priority over toggling.
module t_flip_flop #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= ~r_q;
        end
    end

    // q comes straight from the flop, so no input reaches it combinationally.
    assign q = r_q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: reset hold, toggling, mid-sequence reset,
// release, and a reset pulse that does not span a rising edge.
module tb_t_flip_flop;

    logic clk;
    logic reset;
    logic q;

    int unsigned n_tests;
    int unsigned n_failed;

    t_flip_flop #(.RESET_VAL(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    // Rising edges at 5, 15, 25 ...; falling edges at 10, 20, 30 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_q(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: q=%b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Wait one falling edge (the previous rising edge has settled), then compare.
    task automatic sample(input string tag, input logic exp);
        @(negedge clk);
        check_q(tag, q, exp);
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        reset    = 1'b1;

        sample("reset_hold", 1'b0);

        reset = 1'b0;
        sample("toggle0", 1'b1);
        sample("toggle1", 1'b0);
        sample("toggle2", 1'b1);
        sample("toggle3", 1'b0);

        sample("reach_one", 1'b1);
        reset = 1'b1;
        sample("reset_from_one", 1'b0);

        sample("hold_edge1", 1'b0);
        sample("hold_edge2", 1'b0);

        reset = 1'b0;
        sample("release1", 1'b1);
        sample("release2", 1'b0);

        // Pulse reset inside the low phase while q=1; no rising edge sees it.
        sample("pre_pulse", 1'b1);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_q("after_pulse", q, 1'b1);
        sample("pulse_toggle", 1'b0);
        sample("pulse_toggle2", 1'b1);
        sample("pulse_toggle3", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    // Bound the run in case the clock or sequence stalls.
    initial begin
        #10000;
        $display("FAIL timeout: simulation exceeded 10000 time units");
        $fatal(1, "timeout");
    end

endmodule
